// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
//
// Purpose:
//   Maintains the single pipe currently on screen for the collision checker.
//   The pipe scrolls left by a fixed step on each frame tick. When it reaches
//   the left screen edge it respawns at the right screen edge, with a new
//   pseudo-random gap height. The block also counts the pipes the bird has
//   passed. It follows the collision checker's Start/Ack/Lose handshake:
//   IDLE -> SCROLL on Start, SCROLL -> FROZEN on Lose, FROZEN -> IDLE on Ack.
//
// Configuration macro:
//   PIPE_SPEEDUP_EN - when defined, the scroll step grows by 1 px for every
//                     8 points scored, capped at 2*SCROLL_STEP. When it is
//                     undefined, the step is the constant SCROLL_STEP.
//
// Ports:
//   Clk            in   system clock
//   reset          in   synchronous, active-low reset
//   Start          in   begin a game
//   Ack            in   acknowledge a loss
//   Lose           in   loss indication from the collision checker
//   Tick           in   one-cycle frame pulse
//   X_Edge_Left    out  pipe left edge (saturates at 0)
//   X_Edge_Right   out  pipe right edge
//   Y_Edge_Top     out  bottom of the upper pipe
//   Y_Edge_Bottom  out  top of the lower pipe
//   Score          out  pipes passed this game (saturates at 255)
//   Score_Pulse    out  one-cycle pulse on each score increment
//   Q_Idle/Q_Scroll/Q_Frozen  out  one-hot state
// -----------------------------------------------------------------------------
module pipe_scroller #(
    parameter int SCREEN_W    = 640,
    parameter int PIPE_W      = 40,
    parameter int GAP_H       = 120,
    parameter int Y_MIN       = 60,
    parameter int Y_MAX       = 300,
    parameter int SCROLL_STEP = 2,
    parameter int BIRD_X      = 200
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Lose,
    input  logic       Tick,
    output logic [9:0] X_Edge_Left,
    output logic [9:0] X_Edge_Right,
    output logic [9:0] Y_Edge_Top,
    output logic [9:0] Y_Edge_Bottom,
    output logic [7:0] Score,
    output logic       Score_Pulse,
    output logic       Q_Idle,
    output logic       Q_Scroll,
    output logic       Q_Frozen
);

    localparam int         RANGE     = Y_MAX - Y_MIN;
    localparam logic [9:0] XR_SPAWN  = 10'(SCREEN_W + PIPE_W);
    localparam logic [9:0] Y_TOP_RST = 10'(Y_MIN + RANGE / 2);
    localparam logic [9:0] PIPE_W10  = 10'(PIPE_W);
    localparam logic [9:0] GAP_H10   = 10'(GAP_H);
    localparam logic [9:0] BIRD_X10  = 10'(BIRD_X);
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCROLL = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1. The bits shifted out of the
    // left-shifted register sit at positions 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        logic fb;
        fb = cur[7] ^ cur[5] ^ cur[4] ^ cur[3];
        return {cur[6:0], fb};
    endfunction

    // Folds the 8-bit random value into the legal gap range. One subtraction
    // is enough because the range is at least 128.
    function automatic logic [9:0] gap_top(input logic [7:0] rnd);
        logic [7:0] off;
        off = rnd;
        if (off > 8'(RANGE)) begin
            off = off - 8'(RANGE);
        end else begin
            off = rnd;
        end
        return 10'(Y_MIN) + {2'b00, off};
    endfunction

    state_t     state_q,  state_d;
    logic [9:0] xr_q,     xr_d;
    logic [9:0] top_q,    top_d;
    logic [7:0] score_q,  score_d;
    logic       pulse_q,  pulse_d;
    logic       passed_q, passed_d;
    logic [7:0] lfsr_q,   lfsr_d;

    logic [9:0] step_s;
    logic [9:0] xr_new_s;

`ifdef PIPE_SPEEDUP_EN
    logic [4:0] bonus_s;

    // Speed bonus: +1 px per 8 points scored before this tick, capped at SCROLL_STEP.
    always_comb begin
        bonus_s = score_q[7:3];
        if (bonus_s > 5'(SCROLL_STEP)) begin
            bonus_s = 5'(SCROLL_STEP);
        end else begin
            bonus_s = score_q[7:3];
        end
        step_s = 10'(SCROLL_STEP) + {5'b00000, bonus_s};
    end
`else
    assign step_s = 10'(SCROLL_STEP);
`endif

    assign xr_new_s = xr_q - step_s;

    // Next-state logic for the game FSM, the pipe position, the gap and the score.
    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        top_d    = top_q;
        score_d  = score_q;
        pulse_d  = 1'b0;
        passed_d = passed_q;
        if (lfsr_q == 8'h00) begin
            lfsr_d = LFSR_SEED;
        end else begin
            lfsr_d = lfsr_next(lfsr_q);
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d  = S_SCROLL;
                    xr_d     = XR_SPAWN;
                    top_d    = gap_top(lfsr_q);
                    score_d  = 8'd0;
                    passed_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCROLL: begin
                // A loss freezes the pipe before any same-cycle movement.
                if (Lose) begin
                    state_d = S_FROZEN;
                end else if (Tick) begin
                    if (xr_q <= step_s) begin
                        xr_d     = XR_SPAWN;
                        top_d    = gap_top(lfsr_q);
                        passed_d = 1'b0;
                    end else begin
                        xr_d = xr_new_s;
                        if ((xr_new_s < BIRD_X10) && !passed_q) begin
                            passed_d = 1'b1;
                            pulse_d  = 1'b1;
                            if (score_q != 8'hFF) begin
                                score_d = score_q + 8'd1;
                            end else begin
                                score_d = score_q;
                            end
                        end else begin
                            passed_d = passed_q;
                        end
                    end
                end else begin
                    state_d = S_SCROLL;
                end
            end
            S_FROZEN: begin
                if (Ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FROZEN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            xr_q     <= XR_SPAWN;
            top_q    <= Y_TOP_RST;
            score_q  <= 8'd0;
            pulse_q  <= 1'b0;
            passed_q <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            top_q    <= top_d;
            score_q  <= score_d;
            pulse_q  <= pulse_d;
            passed_q <= passed_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign X_Edge_Right  = xr_q;
    assign X_Edge_Left   = (xr_q > PIPE_W10) ? (xr_q - PIPE_W10) : 10'd0;
    assign Y_Edge_Top    = top_q;
    assign Y_Edge_Bottom = top_q + GAP_H10;
    assign Score         = score_q;
    assign Score_Pulse   = pulse_q;
    assign Q_Idle        = (state_q == S_IDLE);
    assign Q_Scroll      = (state_q == S_SCROLL);
    assign Q_Frozen      = (state_q == S_FROZEN);

endmodule

// File: tb/tb_pipe_scroller.sv
// -----------------------------------------------------------------------------
// tb_pipe_scroller
//
// Table-driven bench for pipe_scroller. Each record holds the input levels,
// the number of cycles those levels are applied, and the outputs expected
// after the last of those cycles. A reference LFSR in the bench supplies the
// expected gap position whenever a record ends with a gap draw.
// -----------------------------------------------------------------------------
module tb_pipe_scroller;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       Lose = 1'b0;
    logic       Tick = 1'b0;
    logic [9:0] X_Edge_Left;
    logic [9:0] X_Edge_Right;
    logic [9:0] Y_Edge_Top;
    logic [9:0] Y_Edge_Bottom;
    logic [7:0] Score;
    logic       Score_Pulse;
    logic       Q_Idle;
    logic       Q_Scroll;
    logic       Q_Frozen;

    int checks = 0;
    int errors = 0;

    pipe_scroller dut (
        .Clk          (Clk),
        .reset        (reset),
        .Start        (Start),
        .Ack          (Ack),
        .Lose         (Lose),
        .Tick         (Tick),
        .X_Edge_Left  (X_Edge_Left),
        .X_Edge_Right (X_Edge_Right),
        .Y_Edge_Top   (Y_Edge_Top),
        .Y_Edge_Bottom(Y_Edge_Bottom),
        .Score        (Score),
        .Score_Pulse  (Score_Pulse),
        .Q_Idle       (Q_Idle),
        .Q_Scroll     (Q_Scroll),
        .Q_Frozen     (Q_Frozen)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, shifting every clock.
    logic [7:0] m_lfsr = 8'hA5;
    always @(posedge Clk) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic int fold_top(input logic [7:0] r);
        int off;
        off = int'(r);
        if (off > 240) off = off - 240;
        return 60 + off;
    endfunction

    typedef struct {
        logic       rst;
        logic       start;
        logic       ack;
        logic       lose;
        logic       tick;
        int         n;
        int         right;
        int         score;
        logic [2:0] st;      // {idle, scroll, frozen}
        logic       pulse;
        logic       newgap;
    } vec_t;

    localparam logic [2:0] IDL = 3'b100;
    localparam logic [2:0] SCR = 3'b010;
    localparam logic [2:0] FRZ = 3'b001;

    vec_t vt[20];
    int   nvec = 0;
    int   exp_top = 180;

    function automatic vec_t mk(logic rst, logic st_, logic ak, logic ls, logic tk, int n,
                                int right, int score, logic [2:0] st, logic pulse, logic ng);
        vec_t v;
        v.rst = rst; v.start = st_; v.ack = ak; v.lose = ls; v.tick = tk; v.n = n;
        v.right = right; v.score = score; v.st = st; v.pulse = pulse; v.newgap = ng;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        string tag;
        int    exp_left;
        tag = $sformatf("vec%0d", idx);
        exp_left = (v.right > 40) ? v.right - 40 : 0;
        chk({tag, " right"},  int'(X_Edge_Right), v.right);
        chk({tag, " left"},   int'(X_Edge_Left), exp_left);
        chk({tag, " score"},  int'(Score), v.score);
        chk({tag, " state"},  int'({Q_Idle, Q_Scroll, Q_Frozen}), int'(v.st));
        chk({tag, " pulse"},  int'(Score_Pulse), int'(v.pulse));
        chk({tag, " top"},    int'(Y_Edge_Top), exp_top);
        chk({tag, " bottom"}, int'(Y_Edge_Bottom), exp_top + 120);
    endtask

`ifdef PIPE_SPEEDUP_EN
    task automatic run_to_score(input int target);
        int k;
        k = 0;
        while (int'(Score) < target && k < 20000) begin
            Tick = 1'b1;
            cyc();
            k++;
        end
        Tick = 1'b0;
        chk($sformatf("reach score %0d", target), (int'(Score) >= target) ? 1 : 0, 1);
    endtask

    task automatic check_step(input int exp_step);
        int  prev;
        bit  done;
        done = 0;
        for (int t = 0; t < 4 && !done; t++) begin
            prev = int'(X_Edge_Right);
            Tick = 1'b1;
            cyc();
            Tick = 1'b0;
            if (int'(X_Edge_Right) != 680) begin
                chk($sformatf("step at score %0d", Score), prev - int'(X_Edge_Right), exp_step);
                done = 1;
            end
        end
        chk("step measured", done ? 1 : 0, 1);
    endtask
`endif

    initial begin
        // Reset and first game: score on tick 241 (xr 198), respawn on tick 340.
        vt[nvec++] = mk(0,0,0,0,0,   2, 680, 0, IDL, 0, 0);
        vt[nvec++] = mk(1,0,0,0,0,   1, 680, 0, IDL, 0, 0);
        vt[nvec++] = mk(1,1,0,0,0,   1, 680, 0, SCR, 0, 1);
        vt[nvec++] = mk(1,0,0,0,1, 240, 200, 0, SCR, 0, 0);
        vt[nvec++] = mk(1,0,0,0,1,   1, 198, 1, SCR, 1, 0);
        vt[nvec++] = mk(1,0,0,0,0,   1, 198, 1, SCR, 0, 0);
        // Start is ignored while scrolling; the tick still moves the pipe.
        vt[nvec++] = mk(1,1,0,0,1,   1, 196, 1, SCR, 0, 0);
        vt[nvec++] = mk(1,0,0,0,1,  97,   2, 1, SCR, 0, 0);
        vt[nvec++] = mk(1,0,0,0,1,   1, 680, 1, SCR, 0, 1);
        vt[nvec++] = mk(1,0,0,0,1, 140, 400, 1, SCR, 0, 0);
        // Lose wins over a same-cycle Tick, then the pipe is frozen.
        vt[nvec++] = mk(1,0,0,1,1,   1, 400, 1, FRZ, 0, 0);
        vt[nvec++] = mk(1,0,0,0,1,  10, 400, 1, FRZ, 0, 0);
        vt[nvec++] = mk(1,0,1,0,0,   1, 400, 1, IDL, 0, 0);
        vt[nvec++] = mk(1,0,0,0,1,   3, 400, 1, IDL, 0, 0);
        vt[nvec++] = mk(1,1,0,0,0,   1, 680, 0, SCR, 0, 1);
        // Three full passes, then reset mid-scroll at xr=300, score 3.
        vt[nvec++] = mk(1,0,0,0,1,1020, 680, 3, SCR, 0, 1);
        vt[nvec++] = mk(1,0,0,0,1, 190, 300, 3, SCR, 0, 0);
        vt[nvec++] = mk(0,0,0,0,1,   1, 680, 0, IDL, 0, 0);
        vt[nvec++] = mk(1,0,0,0,0,   1, 680, 0, IDL, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            for (int c = 0; c < vt[i].n; c++) begin
                reset = vt[i].rst;
                Start = vt[i].start;
                Ack   = vt[i].ack;
                Lose  = vt[i].lose;
                Tick  = vt[i].tick;
                if (!vt[i].rst) begin
                    exp_top = 180;
                end else if (c == vt[i].n - 1 && vt[i].newgap) begin
                    exp_top = fold_top(m_lfsr);
                end
                cyc();
            end
            reset = 1'b1;
            Start = 1'b0;
            Ack   = 1'b0;
            Lose  = 1'b0;
            Tick  = 1'b0;
            check_all(i, vt[i]);
        end

`ifdef PIPE_SPEEDUP_EN
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        run_to_score(8);
        check_step(3);
        run_to_score(16);
        check_step(4);
        run_to_score(40);
        check_step(4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Produces the edges of the pipe currently in scope (X_Edge_Left/Right, Y_Edge_Top/Bottom) for the collision checker.
- Scrolls the pipe left once per frame tick, respawns it at the right screen edge with a pseudo-random gap, and keeps the score.
- Follows the collision checker's Start/Ack/Lose handshake: scrolling starts on Start, freezes on Lose, and returns to idle on Ack.

Parameters:
- SCREEN_W, 640: spawn reference x in pixels.
- PIPE_W, 40: pipe width in pixels.
- GAP_H, 120: vertical gap height in pixels.
- Y_MIN, 60: minimum Y_Edge_Top.
- Y_MAX, 300: maximum Y_Edge_Top. Requires Y_MAX-Y_MIN in 128..255.
- SCROLL_STEP, 2: pixels moved per Tick. Range 1..15.
- BIRD_X, 200: x the pipe's right edge must pass to score. Requires BIRD_X > PIPE_W+2*SCROLL_STEP.

Ports:
- Clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- Start  in  1  begin a game; shared with the collision checker.
- Ack  in  1  acknowledge a loss.
- Lose  in  1  Q_Lose from the collision checker.
- Tick  in  1  one-cycle frame pulse.
- X_Edge_Left  out  10  pipe left edge.
- X_Edge_Right  out  10  pipe right edge.
- Y_Edge_Top  out  10  bottom of the upper pipe.
- Y_Edge_Bottom  out  10  top of the lower pipe.
- Score  out  8  pipes passed this game.
- Score_Pulse  out  1  one-cycle pulse on each score increment.
- Q_Idle, Q_Scroll, Q_Frozen  out  1 each  one-hot state.

Behaviour:
- All registers update on posedge Clk. reset=0 sampled at a clock edge overrides everything, including mid-game.
- Reset values:
  - state=IDLE.
  - xr (internal right edge, 10b)=SCREEN_W+PIPE_W (680).
  - Y_Edge_Top=Y_MIN+(Y_MAX-Y_MIN)/2 (180), Y_Edge_Bottom=300.
  - Score=0, Score_Pulse=0, Passed=0.
  - LFSR=8'hA5.
- Edge outputs:
  - X_Edge_Right=xr.
  - X_Edge_Left=(xr>PIPE_W)?xr-PIPE_W:0 (combinational, saturating).
  - Y_Edge_Bottom=Y_Edge_Top+GAP_H.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every clock when not in reset.
  - Never all-zero.
- Gap draw:
  - off=LFSR; if off>(Y_MAX-Y_MIN) then off=off-(Y_MAX-Y_MIN).
  - Y_Edge_Top=Y_MIN+off, registered.
- step = SCROLL_STEP (see Optional Feature).
- IDLE:
  - Outputs hold.
  - Start=1: go to SCROLL next cycle; xr=680; draw a new gap; Score=0; Passed=0.
- SCROLL:
  - Lose=1: go to FROZEN. Lose has priority over a same-cycle Tick, so no move and no score on that cycle.
  - Else, on Tick, if xr<=step: respawn. xr=680, new gap, Passed=0.
  - Else, on Tick: xr=xr-step. If the new xr<BIRD_X and Passed=0, then Passed=1, Score=Score+1 (saturating at 255), and Score_Pulse=1 for exactly the next cycle.
  - No Tick: hold.
  - Start is ignored.
- FROZEN:
  - All edges and Score hold; Tick is ignored.
  - Ack=1: go to IDLE next cycle. Score is kept until the next Start.
- Score_Pulse is 0 in every cycle not described above.
- Latency: edges change the cycle after the qualifying Tick or Start.
- Illegal state encoding: recovers to IDLE on the next clock.

Optional Feature:
- Macro PIPE_SPEEDUP_EN.
- Defined: step=SCROLL_STEP+min(Score>>3, SCROLL_STEP). The speed rises by 1 px every 8 points, capped at 2*SCROLL_STEP. The step is computed from Score before the current Tick; the same step is used in the respawn comparison.
- Undefined: step=SCROLL_STEP constant; no extra logic.

Test Plan:
- Reset low 2 cycles, then high -> Q_Idle=1, X_Edge_Right=680, X_Edge_Left=640, Y_Edge_Top=180, Y_Edge_Bottom=300, Score=0.
- Start pulse, then 241 Ticks -> X_Edge_Right=198, X_Edge_Left=158, Score=1. Score_Pulse high exactly one cycle after Tick 241. Ticks 242..339 give no further score.
- Continue to Tick 340 (xr was 2) -> X_Edge_Right=680. New Y_Edge_Top in [60,300]; Y_Edge_Bottom=Y_Edge_Top+120.
- Lose and Tick asserted in the same cycle at xr=400 -> Q_Frozen=1, xr stays 400. 10 further Ticks leave it at 400. Ack -> Q_Idle; Score retained. Start -> Score=0, xr=680.
- Reset low mid-scroll at xr=300, Score=3 -> next cycle xr=680, Score=0, Q_Idle=1.
- PIPE_SPEEDUP_EN defined: force Score to 8 via play -> pipe moves 3 px per Tick. At Score>=16 it moves 4 px per Tick, and still 4 at Score=40.
